// File: rtl/nv_fifo_rws_256x7_ctrl.sv
// rtl/nv_fifo_rws_256x7_ctrl.sv - valid/ready FIFO controller driving an external 256x7 registered-read-address RAM
module nv_fifo_rws_256x7_ctrl #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 7
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          wr_pvld,
  output logic          wr_prdy,
  input  logic [DW-1:0] wr_pd,
  output logic          rd_pvld,
  input  logic          rd_prdy,
  output logic [DW-1:0] rd_pd,
  output logic [AW:0]   fifo_count,
  output logic          ram_we,
  output logic [AW-1:0] ram_wa,
  output logic [DW-1:0] ram_di,
  output logic          ram_re,
  output logic [AW-1:0] ram_ra,
  input  logic [DW-1:0] ram_dout,
  input  logic [31:0]   pwrbus_ram_pd,
  output logic [31:0]   ram_pwrbus_pd
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic          staged_q, staged_d;
  logic          wr_prdy_q, wr_prdy_d;
  logic          push_acc, pop_acc;
  logic [AW:0]   fetchable;

  // Handshakes and RAM strobes; the staged entry lives in the RAM output
  // register, so a refetch is only allowed when that slot is empty or
  // being drained this cycle.
  always_comb begin
    push_acc  = wr_pvld & wr_prdy_q;
    pop_acc   = staged_q & rd_prdy;
    fetchable = occ_q - {{AW{1'b0}}, staged_q};
    ram_re    = (fetchable != '0) & (~staged_q | pop_acc);
    ram_we    = push_acc;
    ram_wa    = wr_ptr_q;
    ram_di    = wr_pd;
    ram_ra    = rd_ptr_q;
    occ_d     = occ_q + {{AW{1'b0}}, push_acc} - {{AW{1'b0}}, pop_acc};
    wr_prdy_d = (occ_d < FULL_CNT);
    wr_ptr_d  = push_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = ram_re ? rd_ptr_q + 1'b1 : rd_ptr_q;
    if (ram_re) begin
      staged_d = 1'b1;
    end else if (pop_acc) begin
      staged_d = 1'b0;
    end else begin
      staged_d = staged_q;
    end
  end

  // Control state register; asynchronous reset discards any in-flight data.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      staged_q  <= 1'b0;
      wr_prdy_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      staged_q  <= staged_d;
      wr_prdy_q <= wr_prdy_d;
    end
  end

  assign wr_prdy       = wr_prdy_q;
  assign rd_pvld       = staged_q;
  assign rd_pd         = ram_dout;
  assign fifo_count    = occ_q;
  assign ram_pwrbus_pd = pwrbus_ram_pd;

endmodule

// File: tb/tb_nv_fifo_rws_256x7_ctrl.sv
// tb/tb_nv_fifo_rws_256x7_ctrl.sv - self-checking bench for nv_fifo_rws_256x7_ctrl
module tb_nv_fifo_rws_256x7_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        wr_pvld = 1'b0;
  logic        wr_prdy;
  logic [6:0]  wr_pd = '0;
  logic        rd_pvld;
  logic        rd_prdy = 1'b0;
  logic [6:0]  rd_pd;
  logic [8:0]  fifo_count;
  logic        ram_we;
  logic [7:0]  ram_wa;
  logic [6:0]  ram_di;
  logic        ram_re;
  logic [7:0]  ram_ra;
  logic [6:0]  ram_dout;
  logic [31:0] pwrbus_ram_pd = 32'hA5C3_0F96;
  logic [31:0] ram_pwrbus_pd;

  always #5 clk = ~clk;

  nv_fifo_rws_256x7_ctrl dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rstn(rstn),
    .wr_pvld        (wr_pvld),
    .wr_prdy        (wr_prdy),
    .wr_pd          (wr_pd),
    .rd_pvld        (rd_pvld),
    .rd_prdy        (rd_prdy),
    .rd_pd          (rd_pd),
    .fifo_count     (fifo_count),
    .ram_we         (ram_we),
    .ram_wa         (ram_wa),
    .ram_di         (ram_di),
    .ram_re         (ram_re),
    .ram_ra         (ram_ra),
    .ram_dout       (ram_dout),
    .pwrbus_ram_pd  (pwrbus_ram_pd),
    .ram_pwrbus_pd  (ram_pwrbus_pd)
  );

  // 256x7 RAM: registered read address, combinational dout
  logic [6:0] mem [256];
  logic [7:0] ra_q;
  always @(posedge clk) begin
    if (ram_we) mem[ram_wa] <= ram_di;
    if (ram_re) ra_q <= ram_ra;
  end
  assign ram_dout = mem[ra_q];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  typedef struct {
    logic       pv;
    logic [6:0] d;
    logic       pr;
    logic       e_wrdy;
    logic       e_rvld;
    logic [6:0] e_pd;
    logic [8:0] e_cnt;
    logic       e_we;
    logic [7:0] e_wa;
    logic       e_re;
    logic [7:0] e_ra;
  } vec_t;

  vec_t vecs[12];

  // reference model state
  logic [6:0] q[$];
  logic [7:0] mdl_wptr = '0;
  logic [7:0] mdl_rptr = '0;
  logic       prev_stall = 1'b0;
  logic [6:0] prev_pd = '0;
  int         push_cnt = 0;
  int         pop_cnt = 0;
  logic       last_wr_prdy;
  logic       last_pop;

  task automatic step(input logic pv, input logic [6:0] d, input logic pr);
    logic pa, pp;
    int   sz;
    @(negedge clk);
    wr_pvld = pv; wr_pd = d; rd_prdy = pr;
    #1;
    sz = q.size();
    pa = wr_pvld & wr_prdy;
    pp = rd_pvld & rd_prdy;
    last_wr_prdy = wr_prdy;
    last_pop = pp;
    chk("fifo_count", int'(fifo_count), sz);
    chk("wr_prdy", int'(wr_prdy), (sz < 256) ? 1 : 0);
    chk("ram_we", int'(ram_we), int'(pv & (sz < 256)));
    if (sz == 0) begin
      chk("empty_rd_pvld", int'(rd_pvld), 0);
      chk("empty_ram_re", int'(ram_re), 0);
    end
    if (prev_stall) begin
      chk("stall_rd_pvld", int'(rd_pvld), 1);
      chk("stall_rd_pd", int'(rd_pd), int'(prev_pd));
    end
    if (rd_pvld && !rd_prdy) chk("stall_no_re", int'(ram_re), 0);
    if (pa) begin
      chk("ram_wa", int'(ram_wa), int'(mdl_wptr));
      chk("ram_di", int'(ram_di), int'(d));
      mdl_wptr++;
      push_cnt++;
    end
    if (ram_re) begin
      chk("ram_ra", int'(ram_ra), int'(mdl_rptr));
      mdl_rptr++;
    end
    if (pp) begin
      if (sz == 0) chk("pop_underflow", 1, 0);
      else chk("rd_pd_order", int'(rd_pd), int'(q.pop_front()));
      pop_cnt++;
    end
    if (pa) q.push_back(d);
    prev_stall = rd_pvld & ~rd_prdy;
    prev_pd = rd_pd;
  endtask

  initial begin
    int cyc, first_pop, last_pop_cyc, target, guard;

    vecs[0]  = '{1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 7'h00, 9'd0, 1'b0, 8'd0, 1'b0, 8'd0};
    vecs[1]  = '{1'b0, 7'h00, 1'b1, 1'b1, 1'b0, 7'h00, 9'd0, 1'b0, 8'd0, 1'b0, 8'd0};
    vecs[2]  = '{1'b1, 7'h55, 1'b1, 1'b1, 1'b0, 7'h00, 9'd0, 1'b1, 8'd0, 1'b0, 8'd0};
    vecs[3]  = '{1'b0, 7'h00, 1'b1, 1'b1, 1'b0, 7'h00, 9'd1, 1'b0, 8'd0, 1'b1, 8'd0};
    vecs[4]  = '{1'b0, 7'h00, 1'b1, 1'b1, 1'b1, 7'h55, 9'd1, 1'b0, 8'd0, 1'b0, 8'd0};
    vecs[5]  = '{1'b0, 7'h00, 1'b1, 1'b1, 1'b0, 7'h00, 9'd0, 1'b0, 8'd0, 1'b0, 8'd0};
    vecs[6]  = '{1'b1, 7'h11, 1'b0, 1'b1, 1'b0, 7'h00, 9'd0, 1'b1, 8'd1, 1'b0, 8'd0};
    vecs[7]  = '{1'b1, 7'h22, 1'b0, 1'b1, 1'b0, 7'h00, 9'd1, 1'b1, 8'd2, 1'b1, 8'd1};
    vecs[8]  = '{1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 7'h11, 9'd2, 1'b0, 8'd0, 1'b0, 8'd0};
    vecs[9]  = '{1'b0, 7'h00, 1'b1, 1'b1, 1'b1, 7'h11, 9'd2, 1'b0, 8'd0, 1'b1, 8'd2};
    vecs[10] = '{1'b0, 7'h00, 1'b1, 1'b1, 1'b1, 7'h22, 9'd1, 1'b0, 8'd0, 1'b0, 8'd0};
    vecs[11] = '{1'b0, 7'h00, 1'b1, 1'b1, 1'b0, 7'h00, 9'd0, 1'b0, 8'd0, 1'b0, 8'd0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_prdy", int'(wr_prdy), 0);
    chk("rst_rd_pvld", int'(rd_pvld), 0);
    chk("rst_fifo_count", int'(fifo_count), 0);
    chk("pwrbus_fwd", int'(ram_pwrbus_pd), int'(32'hA5C3_0F96));

    // reset release, single push latency, back-to-back push with stall
    foreach (vecs[i]) begin
      @(negedge clk);
      if (i == 0) rstn = 1'b1;
      wr_pvld = vecs[i].pv; wr_pd = vecs[i].d; rd_prdy = vecs[i].pr;
      #1;
      chk($sformatf("v%0d_wr_prdy", i), int'(wr_prdy), int'(vecs[i].e_wrdy));
      chk($sformatf("v%0d_rd_pvld", i), int'(rd_pvld), int'(vecs[i].e_rvld));
      chk($sformatf("v%0d_fifo_count", i), int'(fifo_count), int'(vecs[i].e_cnt));
      chk($sformatf("v%0d_ram_we", i), int'(ram_we), int'(vecs[i].e_we));
      chk($sformatf("v%0d_ram_re", i), int'(ram_re), int'(vecs[i].e_re));
      if (vecs[i].e_rvld) chk($sformatf("v%0d_rd_pd", i), int'(rd_pd), int'(vecs[i].e_pd));
      if (vecs[i].e_we) chk($sformatf("v%0d_ram_wa", i), int'(ram_wa), int'(vecs[i].e_wa));
      if (vecs[i].e_re) chk($sformatf("v%0d_ram_ra", i), int'(ram_ra), int'(vecs[i].e_ra));
    end
    mdl_wptr = 8'd3;
    mdl_rptr = 8'd3;

    // stream 1000 words, both sides always ready
    push_cnt = 0; pop_cnt = 0; first_pop = -1; last_pop_cyc = -1;
    for (cyc = 0; cyc < 1100 && pop_cnt < 1000; cyc++) begin
      step(push_cnt < 1000, 7'(push_cnt % 128), 1'b1);
      if (last_pop) begin
        if (first_pop < 0) first_pop = cyc;
        last_pop_cyc = cyc;
      end
    end
    chk("stream_pops", pop_cnt, 1000);
    chk("stream_first_pop_cyc", first_pop, 2);
    chk("stream_last_pop_cyc", last_pop_cyc, 1001);
    step(1'b0, 7'h00, 1'b1);

    // fill to full with consumer stalled
    push_cnt = 0;
    for (cyc = 0; cyc < 400 && push_cnt < 256; cyc++) step(1'b1, 7'(cyc), 1'b0);
    chk("fill_accepts", push_cnt, 256);
    step(1'b1, 7'h7f, 1'b0);
    chk("full_wr_prdy", int'(last_wr_prdy), 0);
    chk("full_fifo_count", int'(fifo_count), 256);
    chk("full_no_we", int'(ram_we), 0);
    step(1'b0, 7'h00, 1'b1);
    chk("full_pop", int'(last_pop), 1);
    step(1'b0, 7'h00, 1'b0);
    chk("after_pop_wr_prdy", int'(last_wr_prdy), 1);
    chk("after_pop_fifo_count", int'(fifo_count), 255);
    for (guard = 0; guard < 600 && (q.size() != 0 || rd_pvld); guard++) step(1'b0, 7'h00, 1'b1);
    chk("fill_drained", q.size(), 0);

    // random consumer stalls
    for (cyc = 0; cyc < 800; cyc++)
      step(($urandom % 10) < 7, 7'($urandom), 1'($urandom % 2));
    for (guard = 0; guard < 600 && (q.size() != 0 || rd_pvld); guard++) step(1'b0, 7'h00, 1'b1);
    chk("random_drained", q.size(), 0);

    // asynchronous reset with 10 entries held
    target = push_cnt + 10;
    for (guard = 0; guard < 40 && push_cnt < target; guard++) step(1'b1, 7'(guard + 3), 1'b0);
    chk("held_count", q.size(), 10);
    @(negedge clk);
    wr_pvld = 1'b1; rd_prdy = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("arst_rd_pvld", int'(rd_pvld), 0);
    chk("arst_wr_prdy", int'(wr_prdy), 0);
    chk("arst_fifo_count", int'(fifo_count), 0);
    chk("arst_ram_we", int'(ram_we), 0);
    chk("arst_ram_re", int'(ram_re), 0);
    rd_prdy = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_hold_ram_we", int'(ram_we), 0);
    chk("rst_hold_ram_re", int'(ram_re), 0);
    @(negedge clk);
    rstn = 1'b1; wr_pvld = 1'b0;
    q.delete(); mdl_wptr = '0; mdl_rptr = '0; prev_stall = 1'b0;
    @(negedge clk);
    #1;
    chk("rel_wr_prdy", int'(wr_prdy), 1);
    chk("rel_rd_pvld", int'(rd_pvld), 0);
    chk("rel_fifo_count", int'(fifo_count), 0);
    repeat (3) step(1'b0, 7'h00, 1'b1);
    step(1'b1, 7'h2a, 1'b1);
    repeat (4) step(1'b0, 7'h00, 1'b1);
    chk("post_reset_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
